cpu_control_fsm: RTL and testbench

Multi-cycle control sequencer for the RV32I-subset CPU core. Walks each instruction through fetch, decode, execute, memory and write-back, and drives every datapath select: immediate format to the immediate generator, ALU operand and operation selects, PC update, IR load, memory request and register-file write. Talks to the unified instruction/data memory port through a req/ready handshake and keeps a retired-instruction counter.

---
 rtl/cpu_control_fsm.sv | 233 +++++++++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
// -----------------------------------------------------------------------------
// cpu_control_fsm
//
// Multi-cycle control sequencer for the RV32I-subset core. Each instruction is
// stepped through fetch, decode, execute, memory and write-back. The sequencer
// drives all datapath selects and the unified memory req/ready handshake. It
// also counts retired instructions.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   instruction   current IR contents (only opcode bits [6:0] are used)
//   mem_ready     memory completed the current access this cycle
//   branch_taken  branch comparator result for the IR's funct3
//   mem_req       memory access request
//   mem_we        write enable qualifying mem_req
//   addr_sel      memory address source: 0 = PC, 1 = ALU result
//   ir_write      load IR from memory read data
//   pc_write      update PC this cycle
//   pc_src        0 = PC+4, 1 = branch target
//   imm_sel       immediate format: 00 I, 01 S, 10 B, 11 U
//   alu_src_a     0 = rs1, 1 = old PC
//   alu_src_b     0 = rs2, 1 = imm
//   alu_op        00 add, 10 funct-decoded, 11 pass operand B
//   reg_write     register-file write enable
//   wb_sel        0 = ALU result, 1 = memory read data
//   trap          illegal opcode seen; held until rst
//   instr_count   retired-instruction count (wraps)
//
// State   | meaning
// --------+--------------------------------------------------------------
// IDLE    | post-reset; all outputs low, always moves to FETCH
// FETCH   | read instruction at PC; on ready load IR and step PC by 4
// DECODE  | opcode check; immediate format becomes valid
// EXEC    | ALU operation; branches resolve and retire here
// MEM     | load/store data access; stores retire here
// WB      | register-file write; retire
// TRAP    | illegal opcode; all control low, trap high until rst
// -----------------------------------------------------------------------------
module cpu_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic [1:0]       imm_sel,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             wb_sel,
    output logic             trap,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       retire;

    logic [6:0] opcode;
    logic       unused_instr_bits;

    assign opcode            = instruction[6:0];
    assign unused_instr_bits = ^instruction[31:7];

    logic is_r, is_i_alu, is_load, is_store, is_branch, is_lui, is_auipc;
    logic is_legal;

    assign is_r      = (opcode == OP_R);
    assign is_i_alu  = (opcode == OP_I_ALU);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);
    assign is_legal  = is_r | is_i_alu | is_load | is_store | is_branch
                     | is_lui | is_auipc;

    // Immediate format and ALU selects derived from the opcode alone; they
    // are gated onto the outputs only in the states that use them.
    logic [1:0] imm_dec;
    logic       src_a_dec;
    logic       src_b_dec;
    logic [1:0] alu_op_dec;

    always_comb begin
        imm_dec = 2'b00;
        if (is_store)
            imm_dec = 2'b01;
        else if (is_branch)
            imm_dec = 2'b10;
        else if (is_lui || is_auipc)
            imm_dec = 2'b11;
    end

    always_comb begin
        src_a_dec  = is_auipc;
        src_b_dec  = is_i_alu | is_load | is_store | is_lui | is_auipc;
        alu_op_dec = 2'b00;
        if (is_r || is_i_alu)
            alu_op_dec = 2'b10;
        else if (is_lui)
            alu_op_dec = 2'b11;
    end

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: state_nxt = is_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (is_branch) begin
                    state_nxt = S_FETCH;
                    retire    = 1'b1;
                end else if (is_load || is_store) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (is_store) begin
                        state_nxt = S_FETCH;
                        retire    = 1'b1;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            if (retire)
                instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        imm_sel   = 2'b00;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        alu_op    = 2'b00;
        reg_write = 1'b0;
        wb_sel    = 1'b0;
        trap      = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_DECODE: imm_sel = imm_dec;
            S_EXEC: begin
                imm_sel = imm_dec;
                if (is_branch) begin
                    pc_write = branch_taken;
                    pc_src   = 1'b1;
                end else begin
                    alu_src_a = src_a_dec;
                    alu_src_b = src_b_dec;
                    alu_op    = alu_op_dec;
                end
            end
            S_MEM: begin
                imm_sel   = imm_dec;
                alu_src_a = src_a_dec;
                alu_src_b = src_b_dec;
                alu_op    = alu_op_dec;
                mem_req   = 1'b1;
                addr_sel  = 1'b1;
                mem_we    = is_store;
            end
            S_WB: begin
                imm_sel   = imm_dec;
                alu_src_a = src_a_dec;
                alu_src_b = src_b_dec;
                alu_op    = alu_op_dec;
                reg_write = 1'b1;
                wb_sel    = is_load;
            end
            S_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_cpu_control_fsm
//
// Directed bench for cpu_control_fsm. All control outputs are packed into one
// 15-bit word and compared cycle by cycle against hand-built constants, along
// with the retired-instruction counter.
// -----------------------------------------------------------------------------
module tb_cpu_control_fsm;

    localparam int CNT_W = 32;

    // Packed control word: {mem_req, mem_we, addr_sel, ir_write, pc_write,
    // pc_src, imm_sel[1:0], alu_src_a, alu_src_b, alu_op[1:0], reg_write,
    // wb_sel, trap}
    localparam logic [14:0] NONE  = 15'h0000;
    localparam logic [14:0] REQ   = 15'h4000;
    localparam logic [14:0] WE    = 15'h2000;
    localparam logic [14:0] ASEL  = 15'h1000;
    localparam logic [14:0] IRW   = 15'h0800;
    localparam logic [14:0] PCW   = 15'h0400;
    localparam logic [14:0] PCS   = 15'h0200;
    localparam logic [14:0] IMM_S = 15'h0080;
    localparam logic [14:0] IMM_B = 15'h0100;
    localparam logic [14:0] IMM_U = 15'h0180;
    localparam logic [14:0] SRCA  = 15'h0040;
    localparam logic [14:0] SRCB  = 15'h0020;
    localparam logic [14:0] OP_FN = 15'h0010;
    localparam logic [14:0] OP_B  = 15'h0018;
    localparam logic [14:0] RW    = 15'h0004;
    localparam logic [14:0] WBS   = 15'h0002;
    localparam logic [14:0] TRP   = 15'h0001;

    logic             clk;
    logic             rst;
    logic [31:0]      instruction;
    logic             mem_ready;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_we;
    logic             addr_sel;
    logic             ir_write;
    logic             pc_write;
    logic             pc_src;
    logic [1:0]       imm_sel;
    logic             alu_src_a;
    logic             alu_src_b;
    logic [1:0]       alu_op;
    logic             reg_write;
    logic             wb_sel;
    logic             trap;
    logic [CNT_W-1:0] instr_count;

    logic [14:0] ctrl;
    assign ctrl = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
                   imm_sel, alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
                   trap};

    int n_assert = 0;
    int n_fail   = 0;

    cpu_control_fsm #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .instruction  (instruction),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .addr_sel     (addr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .imm_sel      (imm_sel),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .trap         (trap),
        .instr_count  (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are then changed
    // and outputs checked well before the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctrl(input string tag, input logic [14:0] exp);
        #1;
        n_assert++;
        assert (ctrl === exp) else begin
            n_fail++;
            $error("FAIL %s: ctrl observed %h expected %h", tag, ctrl, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] exp);
        #1;
        n_assert++;
        assert (instr_count === exp) else begin
            n_fail++;
            $error("FAIL %s: instr_count observed %0d expected %0d",
                   tag, instr_count, exp);
        end
    endtask

    initial begin
        rst          = 1'b1;
        instruction  = 32'h0;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;

        // Reset
        tick(); tick();
        chk_ctrl("reset_ctrl", NONE);
        chk_cnt("reset_cnt", 0);
        rst = 1'b0;
        chk_ctrl("idle_ctrl", NONE);

        // ADDI x1,x0,5 with zero wait
        tick();
        mem_ready = 1'b1;
        chk_ctrl("addi_fetch", REQ | IRW | PCW);
        tick();
        instruction = 32'h00500093;
        chk_ctrl("addi_decode", NONE);
        tick();
        chk_ctrl("addi_exec", SRCB | OP_FN);
        tick();
        chk_ctrl("addi_wb", SRCB | OP_FN | RW);
        chk_cnt("addi_cnt_before", 0);
        tick();
        chk_cnt("addi_cnt_after", 1);

        // LW with two wait cycles in MEM
        chk_ctrl("lw_fetch", REQ | IRW | PCW);
        tick();
        instruction = 32'h0000A103;
        chk_ctrl("lw_decode", NONE);
        tick();
        chk_ctrl("lw_exec", SRCB);
        tick();
        mem_ready = 1'b0;
        chk_ctrl("lw_mem_wait1", REQ | ASEL | SRCB);
        tick();
        chk_ctrl("lw_mem_wait2", REQ | ASEL | SRCB);
        tick();
        mem_ready = 1'b1;
        chk_ctrl("lw_mem_ready", REQ | ASEL | SRCB);
        tick();
        chk_ctrl("lw_wb", SRCB | RW | WBS);
        chk_cnt("lw_cnt_before", 1);
        tick();
        chk_cnt("lw_cnt_after", 2);

        // SW
        chk_ctrl("sw_fetch", REQ | IRW | PCW);
        tick();
        instruction = 32'h0020A023;
        chk_ctrl("sw_decode", IMM_S);
        tick();
        chk_ctrl("sw_exec", IMM_S | SRCB);
        tick();
        chk_ctrl("sw_mem", REQ | WE | ASEL | IMM_S | SRCB);
        chk_cnt("sw_cnt_before", 2);
        tick();
        chk_cnt("sw_cnt_after", 3);

        // BEQ taken
        chk_ctrl("beq1_fetch", REQ | IRW | PCW);
        tick();
        instruction  = 32'h00000463;
        branch_taken = 1'b1;
        chk_ctrl("beq1_decode", IMM_B);
        tick();
        chk_ctrl("beq1_exec", IMM_B | PCW | PCS);
        tick();
        chk_cnt("beq1_cnt", 4);

        // BEQ not taken
        branch_taken = 1'b0;
        chk_ctrl("beq2_fetch", REQ | IRW | PCW);
        tick();
        chk_ctrl("beq2_decode", IMM_B);
        tick();
        chk_ctrl("beq2_exec", IMM_B | PCS);
        tick();
        chk_cnt("beq2_cnt", 5);

        // LUI
        chk_ctrl("lui_fetch", REQ | IRW | PCW);
        tick();
        instruction = 32'h123450B7;
        chk_ctrl("lui_decode", IMM_U);
        tick();
        chk_ctrl("lui_exec", IMM_U | SRCB | OP_B);
        tick();
        chk_ctrl("lui_wb", IMM_U | SRCB | OP_B | RW);
        tick();
        chk_cnt("lui_cnt", 6);

        // AUIPC
        chk_ctrl("auipc_fetch", REQ | IRW | PCW);
        tick();
        instruction = 32'h00001097;
        chk_ctrl("auipc_decode", IMM_U);
        tick();
        chk_ctrl("auipc_exec", IMM_U | SRCA | SRCB);
        tick();
        chk_ctrl("auipc_wb", IMM_U | SRCA | SRCB | RW);
        tick();
        chk_cnt("auipc_cnt", 7);

        // ADD (R-type) with one FETCH wait cycle
        mem_ready = 1'b0;
        chk_ctrl("add_fetch_wait", REQ);
        tick();
        mem_ready = 1'b1;
        chk_ctrl("add_fetch_ready", REQ | IRW | PCW);
        tick();
        instruction = 32'h002081B3;
        chk_ctrl("add_decode", NONE);
        tick();
        chk_ctrl("add_exec", OP_FN);
        tick();
        chk_ctrl("add_wb", OP_FN | RW);
        tick();
        chk_cnt("add_cnt", 8);

        // Illegal opcode (JAL) traps and stays trapped
        chk_ctrl("jal_fetch", REQ | IRW | PCW);
        tick();
        instruction = 32'h0000006F;
        chk_ctrl("jal_decode", NONE);
        for (int i = 0; i < 20; i++) begin
            tick();
            mem_ready = i[0];
            chk_ctrl("trap_hold", TRP);
        end
        chk_cnt("trap_cnt", 8);

        // rst clears the trap; FETCH follows one cycle later
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        mem_ready = 1'b0;
        chk_ctrl("trap_clr_idle", NONE);
        chk_cnt("trap_clr_cnt", 0);
        tick();
        chk_ctrl("trap_clr_fetch", REQ);

        // One ADDI so the counter is non-zero before the abort test
        mem_ready = 1'b1;
        chk_ctrl("addi2_fetch", REQ | IRW | PCW);
        tick();
        instruction = 32'h00500093;
        tick();
        tick();
        chk_ctrl("addi2_wb", SRCB | OP_FN | RW);
        tick();
        chk_cnt("addi2_cnt", 1);

        // rst during a FETCH wait aborts cleanly
        mem_ready = 1'b0;
        chk_ctrl("abort_fetch_wait", REQ);
        rst = 1'b1;
        tick();
        chk_ctrl("abort_idle", NONE);
        chk_cnt("abort_cnt", 0);
        mem_ready = 1'b1;
        tick();
        chk_ctrl("abort_held", NONE);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
